// File: rtl/check_collision.sv
// Wall-collision checker for maze sprites: flags whether a one-pixel step in the
// current heading stays on walkable floor, plus a free-running divider counter.
module check_collision (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  PacX,
    input  logic [8:0]  PacY,
    input  logic [1:0]  state,
    output logic        result,
    output logic [31:0] clkdiv
);

    localparam int unsigned CW      = 12;
    localparam int unsigned SPR_EXT = 15;

    localparam logic [1:0] HEAD_UP    = 2'b00;
    localparam logic [1:0] HEAD_DOWN  = 2'b01;
    localparam logic [1:0] HEAD_LEFT  = 2'b10;
    localparam logic [1:0] HEAD_RIGHT = 2'b11;

    typedef logic signed [CW-1:0] coord_t;

    // Signed headroom keeps 0-1 negative and 1023+1 positive, so both land out of bounds.
    function automatic logic overlap(
        input coord_t nx,
        input coord_t ny,
        input int     x0,
        input int     x1,
        input int     y0,
        input int     y1
    );
        return (nx <= coord_t'(x1)) && ((nx + coord_t'(SPR_EXT)) >= coord_t'(x0)) &&
               (ny <= coord_t'(y1)) && ((ny + coord_t'(SPR_EXT)) >= coord_t'(y0));
    endfunction

    coord_t      w_nx;
    coord_t      w_ny;
    logic        w_free;
    logic        w_hit;
    logic        w_ok;
    logic        r_result;
    logic [31:0] r_clkdiv;

    // Prospective top-left after one step in the requested heading.
    always_comb begin
        w_nx = coord_t'({2'b00, PacX});
        w_ny = coord_t'({3'b000, PacY});
        unique case (state)
            HEAD_UP:    w_ny = w_ny - coord_t'(1);
            HEAD_DOWN:  w_ny = w_ny + coord_t'(1);
            HEAD_LEFT:  w_nx = w_nx - coord_t'(1);
            HEAD_RIGHT: w_nx = w_nx + coord_t'(1);
            default:    w_nx = w_nx;
        endcase
    end

    always_comb begin
        w_free = (w_nx >= coord_t'(40)) && ((w_nx + coord_t'(SPR_EXT)) <= coord_t'(599)) &&
                 (w_ny >= coord_t'(40)) && ((w_ny + coord_t'(SPR_EXT)) <= coord_t'(439));
        w_hit  = overlap(w_nx, w_ny, 120, 199, 120, 199) |
                 overlap(w_nx, w_ny, 440, 519, 120, 199) |
                 overlap(w_nx, w_ny, 120, 199, 280, 359) |
                 overlap(w_nx, w_ny, 440, 519, 280, 359) |
                 overlap(w_nx, w_ny, 280, 359, 200, 279);
        w_ok   = w_free && !w_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 1'b0;
            r_clkdiv <= 32'd0;
        end else begin
            r_result <= w_ok;
            r_clkdiv <= r_clkdiv + 32'd1;
        end
    end

    assign result = r_result;
    assign clkdiv = r_clkdiv;

endmodule

// File: tb/tb_check_collision.sv
// Directed bench for check_collision: reset/divider behaviour, borders, wall edges,
// wrap guards and one-cycle result latency.
module tb_check_collision;

    logic        clk;
    logic        rst;
    logic [9:0]  PacX;
    logic [8:0]  PacY;
    logic [1:0]  state;
    logic        result;
    logic [31:0] clkdiv;

    int n_pass  = 0;
    int n_total = 0;

    check_collision u_dut (
        .clk    (clk),
        .rst    (rst),
        .PacX   (PacX),
        .PacY   (PacY),
        .state  (state),
        .result (result),
        .clkdiv (clkdiv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Drive inputs away from the edge, then sample result just after the next rising edge.
    task automatic step(input string tag, input int x, input int y, input logic [1:0] s,
                        input logic exp);
        @(negedge clk);
        PacX  = 10'(x);
        PacY  = 9'(y);
        state = s;
        @(posedge clk);
        #1;
        check(tag, 32'(result), 32'(exp));
    endtask

    typedef struct {
        string      tag;
        int         x;
        int         y;
        logic [1:0] s;
        logic       exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst   = 1'b0;
        PacX  = 10'd45;
        PacY  = 9'd45;
        state = 2'b01;

        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_result_async", 32'(result), 32'd0);
        check("rst_clkdiv_async", clkdiv, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_clkdiv", clkdiv, 32'd0);
        check("rst_hold_result", 32'(result), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge_clkdiv", clkdiv, 32'd1);
        check("first_edge_result", 32'(result), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("clkdiv_after_5", clkdiv, 32'd5);

        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_clkdiv", clkdiv, 32'd0);
        check("midrun_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        vecs = '{
            '{"open_down",      45,  45, 2'b01, 1'b1},
            '{"open_up",        45,  45, 2'b00, 1'b1},
            '{"left_border",    40,  45, 2'b10, 1'b0},
            '{"top_border",     45,  40, 2'b00, 1'b0},
            '{"right_border",  584,  45, 2'b11, 1'b0},
            '{"right_ok",      583,  45, 2'b11, 1'b1},
            '{"bottom_border",  45, 424, 2'b01, 1'b0},
            '{"w0_left_clear", 103, 130, 2'b11, 1'b1},
            '{"w0_left_hit",   104, 130, 2'b11, 1'b0},
            '{"w0_bottom_hit", 150, 200, 2'b00, 1'b0},
            '{"w0_bottom_ok",  150, 201, 2'b00, 1'b1},
            '{"w4_top_hit",    300, 185, 2'b01, 1'b0},
            '{"wrap_up_y0",     45,   0, 2'b00, 1'b0},
            '{"wrap_left_x0",    0,  45, 2'b10, 1'b0},
            '{"wrap_right_max",1023, 45, 2'b11, 1'b0}
        };
        foreach (vecs[i]) step(vecs[i].tag, vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].exp);

        // Alternate left/right at the left border; result must trail the heading by one clk.
        step("seq_prime", 40, 45, 2'b10, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            state = (k % 2 == 0) ? 2'b11 : 2'b10;
            #1;
            check("seq_lag_hold", 32'(result), (k % 2 == 0) ? 32'd0 : 32'd1);
            @(posedge clk);
            #1;
            check("seq_update", 32'(result), (k % 2 == 0) ? 32'd1 : 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
